// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with writeback bypass, stall refresh and stall counter
module id_ex_reg #(
  parameter int XLEN  = 32,
  parameter int CTRLW = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [XLEN-1:0]  ID_PC,
  input  logic [XLEN-1:0]  ID_IMM,
  input  logic [XLEN-1:0]  ID_RS1DATA,
  input  logic [XLEN-1:0]  ID_RS2DATA,
  input  logic [4:0]       ID_RS1ADDR,
  input  logic [4:0]       ID_RS2ADDR,
  input  logic [4:0]       ID_RDADDR,
  input  logic [CTRLW-1:0] ID_CTRL,
  input  logic             ID_VALID,
  input  logic [XLEN-1:0]  WB_DATA,
  input  logic [4:0]       WB_ADDR,
  input  logic             WB_WRITE,
  input  logic             WB_HIT,
  input  logic             STALL,
  input  logic             FLUSH,
  output logic [XLEN-1:0]  EX_PC,
  output logic [XLEN-1:0]  EX_IMM,
  output logic [XLEN-1:0]  EX_RS1DATA,
  output logic [XLEN-1:0]  EX_RS2DATA,
  output logic [4:0]       EX_RS1ADDR,
  output logic [4:0]       EX_RS2ADDR,
  output logic [4:0]       EX_RDADDR,
  output logic [CTRLW-1:0] EX_CTRL,
  output logic             EX_VALID,
  output logic [15:0]      STALL_CNT
);

  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_imm;
  logic [XLEN-1:0]  r_rs1data;
  logic [XLEN-1:0]  r_rs2data;
  logic [4:0]       r_rs1addr;
  logic [4:0]       r_rs2addr;
  logic [4:0]       r_rdaddr;
  logic [CTRLW-1:0] r_ctrl;
  logic             r_valid;
  logic [15:0]      r_stall_cnt;

  logic             w_wb_fire;
  logic [XLEN-1:0]  w_rs1_op;
  logic [XLEN-1:0]  w_rs2_op;
  logic             w_ex_rs1_hit;
  logic             w_ex_rs2_hit;

  // The register file only commits after the edge, so a same-cycle write must be bypassed here.
  assign w_wb_fire    = WB_WRITE & WB_HIT & (WB_ADDR != 5'd0);
  assign w_ex_rs1_hit = w_wb_fire & (WB_ADDR == r_rs1addr);
  assign w_ex_rs2_hit = w_wb_fire & (WB_ADDR == r_rs2addr);

  // Operand select for capture: x0 reads as zero, otherwise bypass a matching writeback.
  always_comb begin
    w_rs1_op = ID_RS1DATA;
    w_rs2_op = ID_RS2DATA;
    if (ID_RS1ADDR == 5'd0) begin
      w_rs1_op = '0;
    end else if (w_wb_fire && (WB_ADDR == ID_RS1ADDR)) begin
      w_rs1_op = WB_DATA;
    end
    if (ID_RS2ADDR == 5'd0) begin
      w_rs2_op = '0;
    end else if (w_wb_fire && (WB_ADDR == ID_RS2ADDR)) begin
      w_rs2_op = WB_DATA;
    end
  end

  // Pipeline register: flush kills, stall holds (refreshing operands), otherwise load from decode.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_pc      <= '0;
      r_imm     <= '0;
      r_rs1data <= '0;
      r_rs2data <= '0;
      r_rs1addr <= '0;
      r_rs2addr <= '0;
      r_rdaddr  <= '0;
      r_ctrl    <= '0;
      r_valid   <= 1'b0;
    end else if (FLUSH) begin
      r_ctrl  <= '0;
      r_valid <= 1'b0;
    end else if (STALL) begin
      // x0 can never match because w_wb_fire excludes WB_ADDR == 0.
      if (r_valid && w_ex_rs1_hit) r_rs1data <= WB_DATA;
      if (r_valid && w_ex_rs2_hit) r_rs2data <= WB_DATA;
    end else begin
      r_pc      <= ID_PC;
      r_imm     <= ID_IMM;
      r_rs1data <= w_rs1_op;
      r_rs2data <= w_rs2_op;
      r_rs1addr <= ID_RS1ADDR;
      r_rs2addr <= ID_RS2ADDR;
      r_rdaddr  <= ID_RDADDR;
      r_ctrl    <= ID_VALID ? ID_CTRL : '0;
      r_valid   <= ID_VALID;
    end
  end

  // Saturating count of cycles a valid instruction was held by STALL.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_stall_cnt <= '0;
    end else if (STALL && !FLUSH && r_valid && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign EX_PC      = r_pc;
  assign EX_IMM     = r_imm;
  assign EX_RS1DATA = r_rs1data;
  assign EX_RS2DATA = r_rs2data;
  assign EX_RS1ADDR = r_rs1addr;
  assign EX_RS2ADDR = r_rs2addr;
  assign EX_RDADDR  = r_rdaddr;
  assign EX_CTRL    = r_ctrl;
  assign EX_VALID   = r_valid;
  assign STALL_CNT  = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - directed self-checking bench for id_ex_reg
module tb_id_ex_reg;

  logic        CLK;
  logic        RESET;
  logic [31:0] ID_PC, ID_IMM, ID_RS1DATA, ID_RS2DATA;
  logic [4:0]  ID_RS1ADDR, ID_RS2ADDR, ID_RDADDR;
  logic [15:0] ID_CTRL;
  logic        ID_VALID;
  logic [31:0] WB_DATA;
  logic [4:0]  WB_ADDR;
  logic        WB_WRITE, WB_HIT;
  logic        STALL, FLUSH;
  logic [31:0] EX_PC, EX_IMM, EX_RS1DATA, EX_RS2DATA;
  logic [4:0]  EX_RS1ADDR, EX_RS2ADDR, EX_RDADDR;
  logic [15:0] EX_CTRL;
  logic        EX_VALID;
  logic [15:0] STALL_CNT;

  int passed = 0;
  int total  = 0;

  id_ex_reg #(.XLEN(32), .CTRLW(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .ID_PC(ID_PC), .ID_IMM(ID_IMM), .ID_RS1DATA(ID_RS1DATA), .ID_RS2DATA(ID_RS2DATA),
    .ID_RS1ADDR(ID_RS1ADDR), .ID_RS2ADDR(ID_RS2ADDR), .ID_RDADDR(ID_RDADDR),
    .ID_CTRL(ID_CTRL), .ID_VALID(ID_VALID),
    .WB_DATA(WB_DATA), .WB_ADDR(WB_ADDR), .WB_WRITE(WB_WRITE), .WB_HIT(WB_HIT),
    .STALL(STALL), .FLUSH(FLUSH),
    .EX_PC(EX_PC), .EX_IMM(EX_IMM), .EX_RS1DATA(EX_RS1DATA), .EX_RS2DATA(EX_RS2DATA),
    .EX_RS1ADDR(EX_RS1ADDR), .EX_RS2ADDR(EX_RS2ADDR), .EX_RDADDR(EX_RDADDR),
    .EX_CTRL(EX_CTRL), .EX_VALID(EX_VALID), .STALL_CNT(STALL_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_id(input logic [31:0] pc, input logic [31:0] imm,
                        input logic [4:0] a1, input logic [31:0] d1,
                        input logic [4:0] a2, input logic [31:0] d2,
                        input logic [4:0] rd, input logic [15:0] ctrl, input logic v);
    ID_PC = pc; ID_IMM = imm; ID_RS1ADDR = a1; ID_RS1DATA = d1;
    ID_RS2ADDR = a2; ID_RS2DATA = d2; ID_RDADDR = rd; ID_CTRL = ctrl; ID_VALID = v;
  endtask

  task automatic set_wb(input logic w, input logic h, input logic [4:0] a, input logic [31:0] d);
    WB_WRITE = w; WB_HIT = h; WB_ADDR = a; WB_DATA = d;
  endtask

  task automatic test_reset;
    RESET = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
    set_id(32'h1, 32'h2, 5'd1, 32'h3, 5'd2, 32'h4, 5'd3, 16'hFFFF, 1'b1);
    set_wb(1'b0, 1'b0, 5'd0, 32'd0);
    step;
    total++;
    if ({EX_PC, EX_IMM, EX_RS1DATA, EX_RS2DATA, EX_RS1ADDR, EX_RS2ADDR, EX_RDADDR,
         EX_CTRL, EX_VALID, STALL_CNT} !== '0)
      $display("FAIL reset_outputs got pc=%h ctrl=%h valid=%b cnt=%h want all zero",
               EX_PC, EX_CTRL, EX_VALID, STALL_CNT);
    else passed++;
    RESET = 1'b1;
  endtask

  task automatic test_load;
    set_id(32'h100, 32'h44, 5'd3, 32'h11, 5'd7, 32'h22, 5'd9, 16'hA5A5, 1'b1);
    step;
    total++;
    if ({EX_PC, EX_IMM, EX_RS1DATA, EX_RS2DATA} !== {32'h100, 32'h44, 32'h11, 32'h22})
      $display("FAIL load_data got pc=%h imm=%h rs1=%h rs2=%h want 100 44 11 22",
               EX_PC, EX_IMM, EX_RS1DATA, EX_RS2DATA);
    else passed++;
    total++;
    if ({EX_RS1ADDR, EX_RS2ADDR, EX_RDADDR, EX_CTRL, EX_VALID} !== {5'd3, 5'd7, 5'd9, 16'hA5A5, 1'b1})
      $display("FAIL load_ctrl got a1=%0d a2=%0d rd=%0d ctrl=%h v=%b want 3 7 9 a5a5 1",
               EX_RS1ADDR, EX_RS2ADDR, EX_RDADDR, EX_CTRL, EX_VALID);
    else passed++;
  endtask

  task automatic test_bypass;
    set_id(32'h104, 32'h0, 5'd5, 32'd7, 5'd6, 32'd8, 5'd1, 16'h0001, 1'b1);
    set_wb(1'b1, 1'b1, 5'd5, 32'd95);
    step;
    total++;
    if (EX_RS1DATA !== 32'd95) $display("FAIL bypass_rs1 got %0d want 95", EX_RS1DATA);
    else passed++;
    total++;
    if (EX_RS2DATA !== 32'd8) $display("FAIL bypass_rs2_nomatch got %0d want 8", EX_RS2DATA);
    else passed++;
  endtask

  task automatic test_x0;
    set_id(32'h108, 32'h0, 5'd0, 32'd55, 5'd0, 32'd123, 5'd1, 16'h0002, 1'b1);
    set_wb(1'b1, 1'b1, 5'd0, 32'd9);
    step;
    total++;
    if (EX_RS2DATA !== 32'd0) $display("FAIL x0_rs2 got %0d want 0", EX_RS2DATA);
    else passed++;
    total++;
    if (EX_RS1DATA !== 32'd0) $display("FAIL x0_rs1 got %0d want 0", EX_RS1DATA);
    else passed++;
  endtask

  task automatic test_no_hit;
    set_id(32'h10C, 32'h0, 5'd1, 32'h77, 5'd1, 32'h88, 5'd2, 16'h0003, 1'b1);
    set_wb(1'b1, 1'b0, 5'd1, 32'd50);
    step;
    total++;
    if (EX_RS1DATA !== 32'h77) $display("FAIL nohit_rs1 got %h want 77", EX_RS1DATA);
    else passed++;
    set_wb(1'b0, 1'b1, 5'd1, 32'd50);
    step;
    total++;
    if (EX_RS2DATA !== 32'h88) $display("FAIL nowrite_rs2 got %h want 88", EX_RS2DATA);
    else passed++;
    set_wb(1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_bubble;
    set_id(32'h110, 32'h5, 5'd2, 32'h1, 5'd3, 32'h2, 5'd4, 16'hFFFF, 1'b0);
    step;
    total++;
    if ({EX_VALID, EX_CTRL, EX_PC} !== {1'b0, 16'h0000, 32'h110})
      $display("FAIL bubble got v=%b ctrl=%h pc=%h want 0 0000 110", EX_VALID, EX_CTRL, EX_PC);
    else passed++;
  endtask

  task automatic test_stall_refresh;
    set_id(32'h200, 32'h99, 5'd4, 32'd1, 5'd4, 32'd2, 5'd10, 16'h1234, 1'b1);
    step;
    STALL = 1'b1;
    set_id(32'hDEAD, 32'hBEEF, 5'd4, 32'd77, 5'd4, 32'd78, 5'd11, 16'h5555, 1'b1);
    step;
    total++;
    if ({EX_RS1DATA, EX_RS2DATA, STALL_CNT} !== {32'd1, 32'd2, 16'd1})
      $display("FAIL stall_c1 got rs1=%0d rs2=%0d cnt=%0d want 1 2 1", EX_RS1DATA, EX_RS2DATA, STALL_CNT);
    else passed++;
    set_wb(1'b1, 1'b1, 5'd4, 32'd6);
    step;
    set_wb(1'b0, 1'b0, 5'd0, 32'd0);
    total++;
    if ({EX_RS1DATA, EX_RS2DATA} !== {32'd6, 32'd6})
      $display("FAIL stall_refresh got rs1=%0d rs2=%0d want 6 6", EX_RS1DATA, EX_RS2DATA);
    else passed++;
    step;
    total++;
    if ({EX_PC, EX_IMM, EX_RS1DATA, EX_RS2DATA, EX_RS1ADDR, EX_RS2ADDR, EX_RDADDR, EX_CTRL, EX_VALID}
        !== {32'h200, 32'h99, 32'd6, 32'd6, 5'd4, 5'd4, 5'd10, 16'h1234, 1'b1})
      $display("FAIL stall_hold got pc=%h imm=%h rs1=%0d rs2=%0d rd=%0d ctrl=%h v=%b want 200 99 6 6 10 1234 1",
               EX_PC, EX_IMM, EX_RS1DATA, EX_RS2DATA, EX_RDADDR, EX_CTRL, EX_VALID);
    else passed++;
    total++;
    if (STALL_CNT !== 16'd3) $display("FAIL stall_cnt got %0d want 3", STALL_CNT);
    else passed++;
  endtask

  task automatic test_flush_stall;
    FLUSH = 1'b1;
    step;
    FLUSH = 1'b0;
    total++;
    if ({EX_VALID, EX_CTRL, STALL_CNT, EX_PC} !== {1'b0, 16'h0, 16'd3, 32'h200})
      $display("FAIL flush_over_stall got v=%b ctrl=%h cnt=%0d pc=%h want 0 0 3 200",
               EX_VALID, EX_CTRL, STALL_CNT, EX_PC);
    else passed++;
    step;
    total++;
    if (STALL_CNT !== 16'd3) $display("FAIL stall_invalid_cnt got %0d want 3", STALL_CNT);
    else passed++;
  endtask

  task automatic test_saturate;
    STALL = 1'b0;
    set_id(32'h300, 32'h1, 5'd8, 32'h81, 5'd9, 32'h91, 5'd12, 16'h00F0, 1'b1);
    step;
    STALL = 1'b1;
    for (int i = 0; i < 65531; i++) @(posedge CLK);
    #1;
    total++;
    if (STALL_CNT !== 16'hFFFE) $display("FAIL sat_pre got %h want fffe", STALL_CNT);
    else passed++;
    step;
    total++;
    if (STALL_CNT !== 16'hFFFF) $display("FAIL sat_reach got %h want ffff", STALL_CNT);
    else passed++;
    step; step; step;
    total++;
    if (STALL_CNT !== 16'hFFFF) $display("FAIL sat_nowrap got %h want ffff", STALL_CNT);
    else passed++;
  endtask

  task automatic test_reset_mid_stall;
    #2 RESET = 1'b0;
    #1;
    total++;
    if ({EX_PC, EX_IMM, EX_RS1DATA, EX_RS2DATA, EX_RS1ADDR, EX_RS2ADDR, EX_RDADDR,
         EX_CTRL, EX_VALID, STALL_CNT} !== '0)
      $display("FAIL async_reset got pc=%h v=%b cnt=%h want all zero", EX_PC, EX_VALID, STALL_CNT);
    else passed++;
    #1 RESET = 1'b1;
    STALL = 1'b0;
    set_id(32'h400, 32'h2, 5'd13, 32'h5, 5'd14, 32'h6, 5'd15, 16'h0F0F, 1'b1);
    step;
    total++;
    if ({EX_PC, EX_RS1DATA, EX_CTRL, EX_VALID, STALL_CNT} !== {32'h400, 32'h5, 16'h0F0F, 1'b1, 16'd0})
      $display("FAIL post_reset_load got pc=%h rs1=%h ctrl=%h v=%b cnt=%0d want 400 5 0f0f 1 0",
               EX_PC, EX_RS1DATA, EX_CTRL, EX_VALID, STALL_CNT);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_load;
    test_bypass;
    test_x0;
    test_no_hit;
    test_bubble;
    test_stall_refresh;
    test_flush_stall;
    test_saturate;
    test_reset_mid_stall;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
